freq_meas_ctrl: RTL and testbench
=================================

Name: freq_meas_ctrl

Overview:
- Sequencer for the pulse-width counter. Runs NUM_AVG back-to-back measurements per request, accumulates the counts, and returns sum and average over a valid/ready result handshake.
- Guards against a stuck or absent input wave with a per-measurement timeout that aborts the counter.
- Sits between the host/display logic and the counter instance.

Parameters:
- LOG2_AVG, 3, log2 of the number of measurements per request; NUM_AVG = 2**LOG2_AVG; legal range 0..8.
- TIMEOUT_CYCLES, 50000000, maximum clk cycles one measurement may take before abort; must be ≥ 4.

Ports:
- clk, input, 1, system clock; every register is on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- req, input, 1, measurement request; sampled only in IDLE.
- busy, output, 1, high whenever state is not IDLE.
- cnt_start, output, 1, one-cycle start pulse to the counter.
- cnt_busy, input, 1, counter busy flag.
- cnt_val, input, 32, counter result; valid while cnt_busy is low after a run.
- cnt_abort, output, 1, one-cycle pulse; system ORs it into the counter's reset.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts the result.
- res_sum, output, 32+LOG2_AVG, sum of NUM_AVG counts.
- res_avg, output, 32, res_sum >> LOG2_AVG (floor).
- res_timeout, output, 1, result was aborted by the timeout.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; all outputs 0; accumulator, index and timer cleared.
  - Takes effect from any state, including mid-measurement. No cnt_abort is issued; the counter shares the system reset.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, ACCUM, RESULT.
- IDLE:
  - If req = 1: clear accumulator, index and timer; go to START.
  - req in any other state is ignored; requests are not queued.
- START: cnt_start = 1 for exactly this cycle; timer cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - cnt_busy = 1 → WAIT_DONE.
  - Covers the one-cycle latency between start and busy.
- WAIT_DONE: cnt_busy = 0 → ACCUM.
- ACCUM:
  - accumulator += zero-extended cnt_val.
  - If index = NUM_AVG-1 → RESULT; otherwise index += 1 → START.
  - Exactly one accumulate per measurement.
- RESULT:
  - res_valid = 1; res_sum, res_avg and res_timeout are registered on entry and held stable while res_valid is high.
  - On res_ready = 1 with res_valid = 1 → IDLE, and res_valid drops the next cycle.
  - res_ready while res_valid = 0 has no effect.
- Timeout:
  - Timer increments each cycle in WAIT_BUSY and WAIT_DONE.
  - When the timer reaches TIMEOUT_CYCLES-1 while still waiting: cnt_abort = 1 for one cycle; res_sum = 0; res_avg = 0; res_timeout = 1; go to RESULT. Partial sums are discarded.
  - If the measurement completes in the same cycle the timer expires, completion wins.
- Arithmetic:
  - Accumulator width 32+LOG2_AVG, so it cannot overflow.
  - res_avg is always the exact floor and fits in 32 bits.
- Timing:
  - busy rises the cycle after req is accepted.
  - Minimum latency from req to res_valid ≈ NUM_AVG × (3 + counter run time) cycles.
- cnt_start and cnt_abort are never both high in the same cycle.

Test Plan:
- LOG2_AVG=2, counter stub returning 100, 102, 98, 101 → res_sum=401, res_avg=100, res_timeout=0; exactly 4 cnt_start pulses, each one cycle wide.
- Same stub, res_ready held low for 20 cycles after res_valid → res_valid and all data stable for all 20 cycles; IDLE the cycle after res_ready; busy falls with it.
- TIMEOUT_CYCLES=16, stub never asserts cnt_busy → cnt_abort pulse exactly 16 cycles after cnt_start; res_timeout=1, res_sum=0, res_avg=0.
- req pulsed during WAIT_DONE of measurement 2 → ignored; still exactly NUM_AVG measurements and a single result.
- rst asserted in WAIT_DONE → the next cycle shows busy=0, res_valid=0, cnt_start=0; a new req then gives a correct fresh result (no residue from the old accumulator).
- LOG2_AVG=0, real counter with wave high for 50 cycles → one measurement; res_avg equals the counter's cnt_val; res_sum equals res_avg.

Source files
------------

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl
// Sequencer for the pulse-width counter. One request runs NUM_AVG back-to-back
// measurements, sums the counts and offers sum/average on a valid/ready
// handshake. Each measurement is guarded by a timeout that aborts the counter.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   req             : start a measurement batch (sampled only when idle)
//   busy            : sequencer is not idle
//   cnt_start       : one-cycle start pulse to the counter
//   cnt_busy        : counter busy flag
//   cnt_val         : counter result, valid while cnt_busy is low after a run
//   cnt_abort       : one-cycle pulse, ORed into the counter reset
//   res_valid       : result available
//   res_ready       : consumer accepts the result
//   res_sum         : sum of NUM_AVG counts
//   res_avg         : floor(res_sum / NUM_AVG)
//   res_timeout     : batch was aborted by the timeout
module freq_meas_ctrl #(
   parameter int LOG2_AVG       = 3,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   output logic                  busy,
   output logic                  cnt_start,
   input  logic                  cnt_busy,
   input  logic [31:0]           cnt_val,
   output logic                  cnt_abort,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [31+LOG2_AVG:0]  res_sum,
   output logic [31:0]           res_avg,
   output logic                  res_timeout
);

   localparam int NUM_AVG = 1 << LOG2_AVG;
   localparam int AW      = 32 + LOG2_AVG;
   // one spare bit so LOG2_AVG = 0 still has a non-empty index
   localparam int IW      = LOG2_AVG + 1;
   // headroom above TIMEOUT_CYCLES: the timer may step once past expiry
   localparam int TW      = $clog2(TIMEOUT_CYCLES + 2);

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_AVG - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_BUSY, WAIT_DONE, ACCUM, RESULT
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  acc_q;
   logic [AW-1:0]  acc_sum;
   logic [IW-1:0]  idx_q;
   logic [TW-1:0]  timer_q;
   logic           expired;

   assign acc_sum   = acc_q + AW'(cnt_val);
   // >= rather than ==: if busy arrives exactly at expiry the timer keeps
   // running into WAIT_DONE and must still be seen as expired there
   assign expired   = (timer_q >= TMO_LAST);
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == RESULT);

   // next state and counter strobes
   always_comb begin
      state_d   = state_q;
      cnt_start = 1'b0;
      cnt_abort = 1'b0;
      case (state_q)
         IDLE:      if (req) state_d = START;
         START: begin
            cnt_start = 1'b1;
            state_d   = WAIT_BUSY;
         end
         // progress is tested before expiry so completion wins a tie
         WAIT_BUSY: begin
            if (cnt_busy) state_d = WAIT_DONE;
            else if (expired) begin
               cnt_abort = 1'b1;
               state_d   = RESULT;
            end
         end
         WAIT_DONE: begin
            if (!cnt_busy) state_d = ACCUM;
            else if (expired) begin
               cnt_abort = 1'b1;
               state_d   = RESULT;
            end
         end
         ACCUM:     state_d = (idx_q == LAST_IDX) ? RESULT : START;
         RESULT:    if (res_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         timer_q     <= '0;
         res_sum     <= '0;
         res_avg     <= '0;
         res_timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req) begin
                  acc_q   <= '0;
                  idx_q   <= '0;
                  timer_q <= '0;
               end
            end
            START:               timer_q <= '0;
            WAIT_BUSY, WAIT_DONE: timer_q <= timer_q + 1'b1;
            ACCUM: begin
               acc_q <= acc_sum;
               if (idx_q == LAST_IDX) begin
                  // result registers load on entry to RESULT and hold there
                  res_sum     <= acc_sum;
                  res_avg     <= 32'(acc_sum >> LOG2_AVG);
                  res_timeout <= 1'b0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
         // abort discards any partial sum
         if (cnt_abort) begin
            res_sum     <= '0;
            res_avg     <= '0;
            res_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl: dut_a (LOG2_AVG=2, TIMEOUT_CYCLES=16) driven by a
// scripted counter stub, dut_b (LOG2_AVG=0) driven by a pulse-width counter
// model measuring a generated wave. Expected results go into per-DUT queues
// when a request is issued and are popped when res_valid appears.
module tb_freq_meas_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        req_a, busy_a, cnt_start_a, cnt_busy_a, cnt_abort_a;
   logic        res_valid_a, res_ready_a, res_timeout_a;
   logic [31:0] cnt_val_a, res_avg_a;
   logic [33:0] res_sum_a;

   logic        req_b, busy_b, cnt_start_b, cnt_busy_b, cnt_abort_b;
   logic        res_valid_b, res_ready_b, res_timeout_b;
   logic [31:0] cnt_val_b, res_avg_b, res_sum_b;

   freq_meas_ctrl #(.LOG2_AVG(2), .TIMEOUT_CYCLES(16)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .busy(busy_a),
      .cnt_start(cnt_start_a), .cnt_busy(cnt_busy_a), .cnt_val(cnt_val_a),
      .cnt_abort(cnt_abort_a), .res_valid(res_valid_a), .res_ready(res_ready_a),
      .res_sum(res_sum_a), .res_avg(res_avg_a), .res_timeout(res_timeout_a));

   freq_meas_ctrl #(.LOG2_AVG(0), .TIMEOUT_CYCLES(200)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .busy(busy_b),
      .cnt_start(cnt_start_b), .cnt_busy(cnt_busy_b), .cnt_val(cnt_val_b),
      .cnt_abort(cnt_abort_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
      .res_sum(res_sum_b), .res_avg(res_avg_b), .res_timeout(res_timeout_b));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [33:0] sum;
      logic [31:0] avg;
      logic        tmo;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   // ---------------- counter stub for dut_a ----------------
   // busy for 4 cycles after a start, then returns stub_vals[n];
   // starts numbered >= stuck_at never raise busy
   logic [31:0] stub_vals [4];
   int          stuck_at = 4;
   int          st_idx   = 0;
   int          run_a    = 0;

   always @(posedge clk) begin
      if (rst || cnt_abort_a) begin
         cnt_busy_a <= 1'b0;
         run_a      <= 0;
         if (rst) begin
            st_idx    <= 0;
            cnt_val_a <= '0;
         end
      end else if (req_a && !busy_a) begin
         st_idx <= 0;
      end else if (cnt_start_a) begin
         if (st_idx < stuck_at) begin
            cnt_busy_a <= 1'b1;
            run_a      <= 4;
         end
         st_idx <= st_idx + 1;
      end else if (run_a == 1) begin
         cnt_busy_a <= 1'b0;
         run_a      <= 0;
         cnt_val_a  <= stub_vals[2'(st_idx - 1)];
      end else if (run_a > 1) begin
         run_a <= run_a - 1;
      end
   end

   // ---------------- strobe monitor for dut_a ----------------
   int   cyc = 0, n_start = 0, n_wide = 0, n_abort = 0, n_both = 0;
   int   abort_gap = -1, last_start = 0;
   logic start_prev = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         n_start    <= 0;
         n_wide     <= 0;
         n_abort    <= 0;
         n_both     <= 0;
         abort_gap  <= -1;
         start_prev <= 1'b0;
      end else begin
         start_prev <= cnt_start_a;
         if (cnt_start_a) begin
            n_start    <= n_start + 1;
            last_start <= cyc;
            if (start_prev) n_wide <= n_wide + 1;
         end
         if (cnt_abort_a) begin
            n_abort   <= n_abort + 1;
            abort_gap <= cyc - last_start;
            if (cnt_start_a) n_both <= n_both + 1;
         end
      end
   end

   // ---------------- pulse-width counter model for dut_b ----------------
   logic        wave = 1'b0;
   logic        seen_b;
   logic [31:0] ctr_b;

   always @(posedge clk) begin
      if (rst || cnt_abort_b) begin
         cnt_busy_b <= 1'b0;
         cnt_val_b  <= '0;
         ctr_b      <= '0;
         seen_b     <= 1'b0;
      end else if (cnt_start_b) begin
         cnt_busy_b <= 1'b1;
         ctr_b      <= '0;
         seen_b     <= 1'b0;
      end else if (cnt_busy_b) begin
         if (wave) begin
            ctr_b  <= ctr_b + 1;
            seen_b <= 1'b1;
         end else if (seen_b) begin
            cnt_busy_b <= 1'b0;
            cnt_val_b  <= ctr_b;
         end
      end
   end

   // ---------------- helpers (stimulus / bounded waits only) ----------------
   task automatic do_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_valid_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (res_valid_a) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_valid_b(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (res_valid_b) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_starts_a(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (n_start >= n) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic accept_a;
      res_ready_a = 1'b1;
      @(negedge clk);
      res_ready_a = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_a, res_valid_a, cnt_start_a, cnt_abort_a, res_timeout_a} !== 5'b0 ||
          res_sum_a !== 34'd0 || res_avg_a !== 32'd0) begin
         errors++;
         $display("FAIL reset_a got busy=%b vld=%b st=%b ab=%b to=%b sum=%0d avg=%0d want all 0",
                  busy_a, res_valid_a, cnt_start_a, cnt_abort_a, res_timeout_a, res_sum_a, res_avg_a);
      end
      checks++;
      if ({busy_b, res_valid_b, cnt_start_b, cnt_abort_b, res_timeout_b} !== 5'b0 ||
          res_sum_b !== 32'd0 || res_avg_b !== 32'd0) begin
         errors++;
         $display("FAIL reset_b got busy=%b vld=%b sum=%0d avg=%0d want all 0",
                  busy_b, res_valid_b, res_sum_b, res_avg_b);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic;
      bit   ok;
      exp_t e;
      stub_vals = '{32'd100, 32'd102, 32'd98, 32'd101};
      stuck_at  = 4;
      do_reset;
      q_a.push_back('{34'd401, 32'd100, 1'b0});
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin
         errors++; $display("FAIL busy_rise got %b want 1", busy_a);
      end
      wait_valid_a(ok);
      e = q_a.pop_front();
      checks++;
      if (!ok || res_sum_a !== e.sum || res_avg_a !== e.avg || res_timeout_a !== e.tmo) begin
         errors++;
         $display("FAIL basic_result got vld=%b sum=%0d avg=%0d to=%b want sum=%0d avg=%0d to=%b",
                  ok, res_sum_a, res_avg_a, res_timeout_a, e.sum, e.avg, e.tmo);
      end
      checks++;
      if (n_start !== 4 || n_wide !== 0) begin
         errors++; $display("FAIL start_pulses got %0d (wide %0d) want 4 (wide 0)", n_start, n_wide);
      end
      // hold res_ready low: everything must stay put
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (res_valid_a !== 1'b1 || busy_a !== 1'b1 || res_sum_a !== e.sum ||
             res_avg_a !== e.avg || res_timeout_a !== e.tmo) begin
            errors++;
            $display("FAIL hold_%0d got vld=%b busy=%b sum=%0d avg=%0d to=%b want stable result",
                     i, res_valid_a, busy_a, res_sum_a, res_avg_a, res_timeout_a);
         end
      end
      accept_a;
      checks++;
      if (res_valid_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL accept got vld=%b busy=%b want 0 0", res_valid_a, busy_a);
      end
   endtask

   task automatic test_pattern(input logic [31:0] v0, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [31:0] v3);
      bit          ok;
      exp_t        e;
      logic [33:0] s;
      stub_vals = '{v0, v1, v2, v3};
      stuck_at  = 4;
      s = 34'(v0) + 34'(v1) + 34'(v2) + 34'(v3);
      q_a.push_back('{s, s[33:2], 1'b0});
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      wait_valid_a(ok);
      e = q_a.pop_front();
      checks++;
      if (!ok || res_sum_a !== e.sum || res_avg_a !== e.avg || res_timeout_a !== e.tmo) begin
         errors++;
         $display("FAIL pattern got vld=%b sum=%0h avg=%0h to=%b want sum=%0h avg=%0h to=%b",
                  ok, res_sum_a, res_avg_a, res_timeout_a, e.sum, e.avg, e.tmo);
      end
      accept_a;
   endtask

   task automatic test_timeout(input int stuck);
      bit   ok;
      exp_t e;
      stub_vals = '{32'd100, 32'd102, 32'd98, 32'd101};
      stuck_at  = stuck;
      do_reset;
      q_a.push_back('{34'd0, 32'd0, 1'b1});
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      wait_valid_a(ok);
      e = q_a.pop_front();
      checks++;
      if (!ok || res_sum_a !== e.sum || res_avg_a !== e.avg || res_timeout_a !== e.tmo) begin
         errors++;
         $display("FAIL timeout_%0d_result got vld=%b sum=%0d avg=%0d to=%b want 0 0 1",
                  stuck, ok, res_sum_a, res_avg_a, res_timeout_a);
      end
      checks++;
      if (abort_gap !== 16 || n_abort !== 1 || n_both !== 0) begin
         errors++;
         $display("FAIL timeout_%0d_abort got gap=%0d pulses=%0d overlap=%0d want 16 1 0",
                  stuck, abort_gap, n_abort, n_both);
      end
      checks++;
      if (n_start !== stuck + 1) begin
         errors++; $display("FAIL timeout_%0d_starts got %0d want %0d", stuck, n_start, stuck + 1);
      end
      accept_a;
      stuck_at = 4;
   endtask

   task automatic test_req_ignored;
      bit   ok;
      exp_t e;
      int   late_busy;
      stub_vals = '{32'd100, 32'd102, 32'd98, 32'd101};
      stuck_at  = 4;
      do_reset;
      q_a.push_back('{34'd401, 32'd100, 1'b0});
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      wait_starts_a(2, ok);
      repeat (2) @(negedge clk);
      req_a = 1'b1;   // lands in WAIT_DONE of measurement 2
      @(negedge clk);
      req_a = 1'b0;
      wait_valid_a(ok);
      e = q_a.pop_front();
      checks++;
      if (!ok || res_sum_a !== e.sum || res_avg_a !== e.avg || res_timeout_a !== e.tmo) begin
         errors++;
         $display("FAIL req_ignored_result got vld=%b sum=%0d avg=%0d want sum=%0d avg=%0d",
                  ok, res_sum_a, res_avg_a, e.sum, e.avg);
      end
      checks++;
      if (n_start !== 4) begin
         errors++; $display("FAIL req_ignored_starts got %0d want 4", n_start);
      end
      accept_a;
      late_busy = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy_a || res_valid_a) late_busy++;
      end
      checks++;
      if (late_busy !== 0) begin
         errors++; $display("FAIL req_ignored_rerun got %0d busy cycles want 0", late_busy);
      end
   endtask

   task automatic test_rst_mid;
      bit   ok;
      exp_t e;
      stub_vals = '{32'd100, 32'd102, 32'd98, 32'd101};
      stuck_at  = 4;
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      wait_starts_a(2, ok);
      repeat (2) @(negedge clk);
      rst = 1'b1;     // in WAIT_DONE of measurement 2
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || res_valid_a !== 1'b0 || cnt_start_a !== 1'b0 ||
          res_sum_a !== 34'd0 || res_avg_a !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid got busy=%b vld=%b st=%b sum=%0d avg=%0d want all 0",
                  busy_a, res_valid_a, cnt_start_a, res_sum_a, res_avg_a);
      end
      @(negedge clk);
      stub_vals = '{32'd10, 32'd20, 32'd30, 32'd41};
      q_a.push_back('{34'd101, 32'd25, 1'b0});
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      wait_valid_a(ok);
      e = q_a.pop_front();
      checks++;
      if (!ok || res_sum_a !== e.sum || res_avg_a !== e.avg || res_timeout_a !== e.tmo) begin
         errors++;
         $display("FAIL rst_mid_fresh got vld=%b sum=%0d avg=%0d want sum=%0d avg=%0d",
                  ok, res_sum_a, res_avg_a, e.sum, e.avg);
      end
      accept_a;
   endtask

   task automatic test_real_counter(input int width);
      bit   ok;
      exp_t e;
      q_b.push_back('{34'(width), 32'(width), 1'b0});
      req_b = 1'b1;
      @(negedge clk);
      req_b = 1'b0;
      repeat (5) @(negedge clk);
      wave = 1'b1;
      repeat (width) @(negedge clk);
      wave = 1'b0;
      wait_valid_b(ok);
      e = q_b.pop_front();
      checks++;
      if (!ok || res_sum_b !== e.sum[31:0] || res_avg_b !== e.avg || res_timeout_b !== e.tmo) begin
         errors++;
         $display("FAIL real_%0d got vld=%b sum=%0d avg=%0d to=%b want %0d %0d 0",
                  width, ok, res_sum_b, res_avg_b, res_timeout_b, e.sum, e.avg);
      end
      checks++;
      if (res_avg_b !== cnt_val_b || res_sum_b !== res_avg_b) begin
         errors++;
         $display("FAIL real_%0d_cntval got avg=%0d sum=%0d want cnt_val=%0d", width,
                  res_avg_b, res_sum_b, cnt_val_b);
      end
      res_ready_b = 1'b1;
      @(negedge clk);
      res_ready_b = 1'b0;
      checks++;
      if (busy_b !== 1'b0 || res_valid_b !== 1'b0) begin
         errors++; $display("FAIL real_%0d_accept got busy=%b vld=%b want 0 0", width, busy_b, res_valid_b);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_a = 1'b0; res_ready_a = 1'b0;
      req_b = 1'b0; res_ready_b = 1'b0;
      stub_vals = '{32'd0, 32'd0, 32'd0, 32'd0};
      test_reset;
      test_basic;
      test_pattern(32'd7, 32'd0, 32'd0, 32'd0);
      test_pattern(32'd3, 32'd3, 32'd3, 32'd2);
      test_pattern(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      test_timeout(0);
      test_timeout(2);
      test_req_ignored;
      test_rst_mid;
      do_reset;
      test_real_counter(50);
      test_real_counter(13);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
